// File: rtl/transmit_frame_generator.sv
// UART-style transmit frame generator: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Parity support is compiled in when UART_TX_PARITY_EN is defined.
module transmit_frame_generator #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  baud_edge,
    input  logic                  stop_bits_2,
`ifdef UART_TX_PARITY_EN
    input  logic                  parity_en,
    input  logic                  parity_odd,
`endif
    output logic                  txd,
    output logic                  tx_busy,
    output logic                  transmit_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PEND   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic                    stop_cnt_q, stop_cnt_d;
    logic                    stop2_q, stop2_d;
    logic                    txd_q, txd_d;
    logic                    done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                    par_en_q, par_en_d;
    logic                    par_bit_q, par_bit_d;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            stop2_q    <= 1'b0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            stop2_q    <= stop2_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    // txd_d carries the level of the bit that starts at this edge, so the line is registered.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        stop2_d    = stop2_q;
        txd_d      = txd_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d    = PEND;
                    shift_d    = tx_data;
                    stop2_d    = stop_bits_2;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    txd_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_en_d   = parity_en;
                    par_bit_d  = (^tx_data) ^ parity_odd;
`endif
                end
            end
            PEND: begin
                if (baud_edge) begin
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (baud_edge) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
            end
            DATA: begin
                if (baud_edge) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = STOP;
                        stop_cnt_d = 1'b0;
                        txd_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = PARITY;
                            txd_d   = par_bit_q;
                        end
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (baud_edge) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                    txd_d      = 1'b1;
                end
            end
            STOP: begin
                if (baud_edge) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_comb begin
        tx_ready      = (state_q == IDLE);
        tx_busy       = (state_q != IDLE);
        txd           = txd_q;
        transmit_done = done_q;
    end

endmodule

// File: tb/tb_transmit_frame_generator.sv
// Bench for transmit_frame_generator: vector table + scoreboard fed by a mid-bit line sampler.
// Builds with or without UART_TX_PARITY_EN.
module tb_transmit_frame_generator;

    typedef struct {
        logic [7:0] data;
        logic       s2;
        logic       pen;
        logic       podd;
        logic       epar;
        int         elen;
        logic       b2b;
    } vec_t;

    logic       pclk;
    logic       presetn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       baud_edge;
    logic       stop_bits_2;
`ifdef UART_TX_PARITY_EN
    logic       parity_en;
    logic       parity_odd;
`endif
    logic       txd;
    logic       tx_busy;
    logic       transmit_done;

    transmit_frame_generator #(.DATA_WIDTH(8)) dut (
        .pclk         (pclk),
        .presetn      (presetn),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .baud_edge    (baud_edge),
        .stop_bits_2  (stop_bits_2),
`ifdef UART_TX_PARITY_EN
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
`endif
        .txd          (txd),
        .tx_busy      (tx_busy),
        .transmit_done(transmit_done)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t sb[$];
    int   bcnt;
    logic mon_en = 1'b1;
    int   m_phase = 0;
    int   m_cnt   = 0;
    vec_t m_cur;
    int   cyc = 0;
    int   last_done_cyc = 0;
    int   done_cnt = 0;
    int   exp_done = 0;
    logic trk = 1'b0;
    int   lowrun = 0;
    int   maxlow = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic s2, input logic pen,
                                input logic podd, input logic epar, input int elen);
        vec_t v;
        v.data = d; v.s2 = s2; v.pen = pen; v.podd = podd;
        v.epar = epar; v.elen = elen; v.b2b = 1'b0;
        return v;
    endfunction

    function automatic logic exp_bit(input vec_t v, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return v.data[k-1];
        if (v.pen && k == 9) return v.epar;
        return 1'b1;
    endfunction

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Free-running bit clock: one baud_edge every 16 pclk cycles, also while idle.
    initial begin
        bcnt = 0;
        baud_edge = 1'b0;
        forever begin
            @(negedge pclk);
            bcnt = (bcnt + 1) % 16;
            baud_edge = (bcnt == 15);
        end
    end

    initial begin
        forever begin
            @(negedge pclk);
            if (transmit_done === 1'b1) done_cnt++;
            if (trk) begin
                if (tx_busy === 1'b0) lowrun++;
                else lowrun = 0;
                if (lowrun > maxlow) maxlow = lowrun;
            end
        end
    end

    // Line sampler: detects the start bit, samples each bit mid-period, checks done at frame end.
    initial begin
        forever begin
            @(negedge pclk);
            cyc++;
            if (!mon_en) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (txd === 1'b0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_start", 32'd1, 32'd0);
                        m_phase = 2;
                    end else begin
                        m_cur   = sb.pop_front();
                        m_cnt   = 0;
                        m_phase = 1;
                        if (m_cur.b2b) chk("b2b_gap_le16", 32'((cyc - last_done_cyc) <= 16), 32'd1);
                    end
                end
            end else if (m_phase == 1) begin
                m_cnt++;
                if ((m_cnt % 16) == 8 && (m_cnt / 16) < m_cur.elen)
                    chk($sformatf("bit%0d_of_%02h", m_cnt / 16, m_cur.data), 32'(txd),
                        32'(exp_bit(m_cur, m_cnt / 16)));
                if (m_cnt == 16 * m_cur.elen) begin
                    chk($sformatf("done_%02h", m_cur.data), 32'(transmit_done), 32'd1);
                    chk($sformatf("ready_at_done_%02h", m_cur.data), 32'(tx_ready), 32'd1);
                    chk($sformatf("idle_line_%02h", m_cur.data), 32'(txd), 32'd1);
                    last_done_cyc = cyc;
                    m_phase = 0;
                end
            end else begin
                if (tx_busy === 1'b0 && txd === 1'b1) m_phase = 0;
            end
        end
    end

    task automatic step();
        @(negedge pclk);
        #1;
    endtask

    task automatic send(input vec_t v);
        tx_data     = v.data;
        stop_bits_2 = v.s2;
`ifdef UART_TX_PARITY_EN
        parity_en   = v.pen;
        parity_odd  = v.podd;
`endif
        tx_valid    = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (tx_ready === 1'b1) begin
                sb.push_back(v);
                exp_done++;
                step();
                // Scramble inputs after acceptance; the frame in flight must not change.
                tx_valid    = 1'b0;
                tx_data     = ~v.data;
                stop_bits_2 = ~v.s2;
`ifdef UART_TX_PARITY_EN
                parity_en   = ~v.pen;
                parity_odd  = ~v.podd;
`endif
                return;
            end
            step();
        end
        chk("handshake_timeout", 32'd1, 32'd0);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000; i++) begin
            if (tx_busy === 1'b0) return;
            step();
        end
        chk("idle_timeout", 32'd1, 32'd0);
    endtask

    vec_t vecs[6];
    vec_t v;

    initial begin
`ifdef UART_TX_PARITY_EN
        vecs[0] = mk(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        vecs[1] = mk(8'hA3, 1'b0, 1'b1, 1'b0, 1'b0, 11);
        vecs[2] = mk(8'hA3, 1'b0, 1'b1, 1'b1, 1'b1, 11);
        vecs[3] = mk(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 11);
        vecs[4] = mk(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 12);
        vecs[5] = mk(8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 11);
`else
        vecs[0] = mk(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        vecs[1] = mk(8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        vecs[2] = mk(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 11);
        vecs[3] = mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 11);
        vecs[4] = mk(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        vecs[5] = mk(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 10);
`endif
        presetn     = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        stop_bits_2 = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_en   = 1'b0;
        parity_odd  = 1'b0;
`endif
        repeat (3) step();
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(transmit_done), 32'd0);
        presetn = 1'b1;
        repeat (40) step();
        chk("idle_line_stays_high", 32'(txd), 32'd1);

        foreach (vecs[i]) begin
            send(vecs[i]);
            wait_idle();
        end

        // Handshake coinciding with baud_edge: that edge must not start the frame.
        for (int i = 0; i < 40 && bcnt != 15; i++) step();
        v = mk(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        send(v);
        chk("pend_txd_after_hs", 32'(txd), 32'd1);
        chk("pend_busy", 32'(tx_busy), 32'd1);
        repeat (8) step();
        chk("pend_still_high", 32'(txd), 32'd1);
        wait_idle();

        // Back-to-back with tx_valid held through the first frame.
        v = mk(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        send(v);
        lowrun = 0; maxlow = 0; trk = 1'b1;
        v = mk(8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        v.b2b = 1'b1;
        send(v);
        step();
        trk = 1'b0;
        chk("b2b_busy_low_cycles", 32'(maxlow), 32'd1);
        wait_idle();

        // Reset in the middle of data bit 4 (bit value 0), then a clean frame.
        v = mk(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        send(v);
        for (int i = 0; i < 400 && !(m_phase == 1 && m_cnt == 88); i++) step();
        chk("reached_bit4", 32'(m_cnt), 32'd88);
        chk("bit4_low_before_rst", 32'(txd), 32'd0);
        mon_en  = 1'b0;
        presetn = 1'b0;
        exp_done--;
        #1;
        chk("abort_txd", 32'(txd), 32'd1);
        chk("abort_ready", 32'(tx_ready), 32'd1);
        chk("abort_busy", 32'(tx_busy), 32'd0);
        chk("abort_done", 32'(transmit_done), 32'd0);
        repeat (3) step();
        presetn = 1'b1;
        step();
        mon_en = 1'b1;
        chk("abort_sb_empty", 32'(sb.size()), 32'd0);
        repeat (20) step();
        v = mk(8'hC6, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        send(v);
        wait_idle();

        repeat (20) step();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("final_monitor_idle", 32'(m_phase), 32'd0);
        chk("done_pulse_count", 32'(done_cnt), 32'(exp_done));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/transmit_frame_generator.md
TRANSMIT_FRAME_GENERATOR -- requirements
Module: transmit_frame_generator

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame; legal range 5..8.
REQ-002 pclk  input  1  block clock; all state updates on rising edge.
REQ-003 presetn  input  1  asynchronous active-low reset.
REQ-004 tx_data  input  DATA_WIDTH  byte to transmit; valid while tx_valid=1.
REQ-005 tx_valid  input  1  tx_data offered.
REQ-006 tx_ready  output  1  block can accept tx_data this cycle.
REQ-007 baud_edge  input  1  one-pclk pulse per bit period; marks every bit boundary.
REQ-008 stop_bits_2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-009 parity_en  input  1  append parity bit (present only with UART_TX_PARITY_EN).
REQ-010 parity_odd  input  1  0 = even, 1 = odd parity (present only with UART_TX_PARITY_EN).
REQ-011 txd  output  1  serial line, idle high, registered.
REQ-012 tx_busy  output  1  high from handshake until frame end.
REQ-013 transmit_done  output  1  one-cycle pulse at frame end.

Function
REQ-014 The block SHALL implement states IDLE, PEND, START, DATA, PARITY, STOP.
REQ-015 tx_ready SHALL be 1 only in IDLE; handshake = tx_valid & tx_ready on a rising pclk edge.
REQ-016 On handshake the block SHALL load tx_data, stop_bits_2, parity_en, parity_odd into internal registers and enter PEND; later input changes do not affect the frame in flight.
REQ-017 PEND -> START on next baud_edge; txd=0 from the cycle after that edge.
REQ-018 START -> DATA on baud_edge; data sent LSB first, one bit per baud_edge interval, 3-bit bit counter 0..DATA_WIDTH-1.
REQ-019 After bit DATA_WIDTH-1 the baud_edge SHALL move to PARITY if latched parity_en=1, else STOP.
REQ-020 Parity bit = XOR of data bits, inverted when parity_odd=1.
REQ-021 STOP drives txd=1 for one or two bit periods per latched stop_bits_2.
REQ-022 The baud_edge ending the last stop bit SHALL return to IDLE and pulse transmit_done for exactly one cycle, same cycle as tx_ready rises.
REQ-023 Frame length SHALL be 1+DATA_WIDTH+P+S bit periods (P = 0/1, S = 1/2), plus PEND wait (0..1 period).
REQ-024 tx_busy SHALL be high in every state except IDLE.
REQ-025 baud_edge in IDLE SHALL have no effect; tx_valid outside IDLE SHALL be ignored and held by the source.
REQ-026 Back-to-back: tx_valid=1 during the transmit_done cycle SHALL be accepted on that edge, with no txd glitch (txd stays 1 until next START).
REQ-027 baud_edge asserted on the handshake cycle SHALL NOT count; PEND waits for a later edge.

Reset
REQ-028 presetn low SHALL force IDLE, txd=1, tx_ready=1, tx_busy=0, transmit_done=0, counters and shift register 0, immediately and asynchronously.
REQ-029 Reset mid-frame SHALL abort the frame; no transmit_done is generated; the aborted byte is lost.

Configuration
REQ-030 Macro UART_TX_PARITY_EN defined: parity_en and parity_odd ports and PARITY state present per REQ-019/020.
REQ-031 Macro undefined: ports absent, PARITY state unreachable/removed, frame = start + data + stop only.

Verification
REQ-032 tx_data=0x55, 1 stop, no parity, baud_edge every 16 cycles -> txd sequence 0,1,0,1,0,1,0,1,0,1 each 16 cycles; transmit_done one pulse at stop end.
REQ-033 tx_data=0xA3, parity_en=1, parity_odd=0 -> parity bit 0; parity_odd=1 -> parity bit 1; frame 11 periods.
REQ-034 stop_bits_2=1, tx_data=0xFF -> txd high 10 periods after start bit; transmit_done after 2nd stop bit; toggling stop_bits_2 mid-frame has no effect.
REQ-035 Two bytes 0x12, 0x34 with tx_valid held -> second accepted in transmit_done cycle; no idle gap beyond PEND wait; tx_busy drops only between frames for at most one cycle.
REQ-036 presetn pulsed low during DATA bit 4 -> txd=1 same cycle, tx_ready=1, no transmit_done; next byte transmits correctly.
